// File: rtl/neos2test_pio_pkg.sv
// +----------------------------------------------------------------------------
// | neos2test_pio_pkg : register map and edge-type encodings for the PIO slave
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package neos2test_pio_pkg;

  localparam int PIO_MAX_WIDTH = 32;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage : neos2test_pio_pkg

`default_nettype wire

// File: rtl/neos2test_pio_sync_edge.sv
// +----------------------------------------------------------------------------
// | neos2test_pio_sync_edge : two-flop pin synchroniser plus edge-detect delay
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module neos2test_pio_sync_edge
  import neos2test_pio_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int EDGE_TYPE  = EDGE_RISE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] i_pins,
  output logic [DATA_WIDTH-1:0] o_sync,
  output logic [DATA_WIDTH-1:0] o_edge
);

  logic [DATA_WIDTH-1:0] r_s1;
  logic [DATA_WIDTH-1:0] r_s2;
  logic [DATA_WIDTH-1:0] r_s3;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= i_pins;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_sync = r_s2;

  // s3 is only a one-cycle delay of s2, so each pin transition yields a single-cycle pulse
  generate
    if (EDGE_TYPE == EDGE_FALL) begin : g_fall
      assign o_edge = ~r_s2 & r_s3;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
      assign o_edge = r_s2 ^ r_s3;
    end else begin : g_rise
      assign o_edge = r_s2 & ~r_s3;
    end
  endgenerate

endmodule : neos2test_pio_sync_edge

`default_nettype wire

// File: rtl/neos2test_pio_gen.sv
// +----------------------------------------------------------------------------
// | neos2test_pio_gen : Avalon-MM GPIO slave with direction, edge capture, irq
// | Optional OUTSET/OUTCLR registers enabled by macro PIO_BIT_SETCLR_EN
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module neos2test_pio_gen
  import neos2test_pio_pkg::*;
#(
  parameter int                    DATA_WIDTH = 10,
  parameter logic [DATA_WIDTH-1:0] OUT_RESET  = '0,
  parameter logic [DATA_WIDTH-1:0] DIR_RESET  = '1,
  parameter int                    EDGE_TYPE  = EDGE_RISE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] out_en,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] r_data_out;
  logic [DATA_WIDTH-1:0] r_dir;
  logic [DATA_WIDTH-1:0] r_irq_mask;
  logic [DATA_WIDTH-1:0] r_edge_cap;

  logic                  w_wr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_sync;
  logic [DATA_WIDTH-1:0] w_edge;
  logic [DATA_WIDTH-1:0] w_cap_clr;
  logic [DATA_WIDTH-1:0] w_rd;
  logic                  w_unused_wdata;

  assign w_wr           = chipselect && !write_n;
  assign w_wdata        = writedata[DATA_WIDTH-1:0];
  assign w_unused_wdata = ^writedata;
  assign w_cap_clr      = (w_wr && (address == ADDR_EDGECAP)) ? w_wdata : '0;

  neos2test_pio_sync_edge #(
    .DATA_WIDTH (DATA_WIDTH),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .i_pins  (in_port),
    .o_sync  (w_sync),
    .o_edge  (w_edge)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= OUT_RESET;
      r_dir      <= DIR_RESET;
      r_irq_mask <= '0;
      r_edge_cap <= '0;
    end else begin
      // a fresh edge in the same cycle as its W1C must not be lost
      r_edge_cap <= (r_edge_cap & ~w_cap_clr) | w_edge;
      if (w_wr) begin
        case (address)
          ADDR_DATA:    r_data_out <= w_wdata;
          ADDR_DIR:     r_dir      <= w_wdata;
          ADDR_IRQMASK: r_irq_mask <= w_wdata;
`ifdef PIO_BIT_SETCLR_EN
          ADDR_OUTSET:  r_data_out <= r_data_out | w_wdata;
          ADDR_OUTCLR:  r_data_out <= r_data_out & ~w_wdata;
`endif
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_rd = '0;
    case (address)
      ADDR_DATA:    w_rd = (r_dir & r_data_out) | (~r_dir & w_sync);
      ADDR_DIR:     w_rd = r_dir;
      ADDR_IRQMASK: w_rd = r_irq_mask;
      ADDR_EDGECAP: w_rd = r_edge_cap;
      default:      w_rd = '0;
    endcase
  end

  always_comb begin
    readdata                 = '0;
    readdata[DATA_WIDTH-1:0] = w_rd;
  end

  assign out_port = r_data_out;
  assign out_en   = r_dir;
  assign irq      = |(r_edge_cap & r_irq_mask);

endmodule : neos2test_pio_gen

`default_nettype wire

// File: doc/neos2test_pio_gen.md
Name: neos2test_pio_gen

Overview:
- Parametrised Avalon-MM general-purpose I/O slave; next generation of the fixed 10-bit output-only PIO.
- Adds:
  - configurable width
  - per-bit direction
  - synchronised inputs
  - edge capture with maskable interrupt
  - optional atomic bit set/clear
- Sits on the system interconnect as an s1 slave; drives board LEDs/GPIO and raises an interrupt to the Nios II CPU.

Parameters:
- DATA_WIDTH, 10, number of PIO bits (1..32).
- OUT_RESET, 0, reset value of the output data register (DATA_WIDTH bits).
- DIR_RESET, all ones, reset value of the direction register (1 = output).
- EDGE_TYPE, 0, capture edge: 0 rising, 1 falling, 2 any.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  register select (word address).
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits above DATA_WIDTH ignored.
- readdata  out  32  read data; bits above DATA_WIDTH are 0.
- in_port  in  DATA_WIDTH  asynchronous pin inputs.
- out_port  out  DATA_WIDTH  output data register value.
- out_en  out  DATA_WIDTH  per-bit output enable (= direction register).
- irq  out  1  level interrupt.

Behaviour:
- Reset state:
  - data_out = OUT_RESET; dir = DIR_RESET; irq_mask = 0; edge_cap = 0.
  - Synchroniser flops s1, s2, s3 = 0.
  - Hence out_port = OUT_RESET, out_en = DIR_RESET, irq = 0.
- Write condition: chipselect && !write_n. Every register update occurs on the next clk edge.
- Register map:
  - 0 DATA:
    - write loads data_out.
    - read returns, per bit, dir ? data_out : s2.
  - 1 DIR: read/write direction register.
  - 2 IRQMASK: read/write interrupt mask.
  - 3 EDGECAP:
    - read returns edge_cap.
    - write-1-to-clear per bit.
  - 4 OUTSET: write ORs writedata into data_out; reads 0.
  - 5 OUTCLR: write clears the data_out bits set in writedata; reads 0.
  - 6, 7: writes ignored, reads 0.
- Reads:
  - Combinational, zero wait states.
  - readdata is a function of the current address and register state only.
  - chipselect does not gate readdata.
- DATA writes update data_out regardless of dir. Input-direction bits still hold a written value and drive it once switched to output.
- Input path:
  - 2-flop synchroniser in_port -> s1 -> s2, plus s3 as the edge-detect delay.
  - A pin change before clk edge k is readable after edge k+1.
- Edge detect (per bit):
  - rising = s2 & ~s3; falling = ~s2 & s3; any = s2 ^ s3.
  - Applied to all bits; DATA reads of output-direction bits are unaffected.
  - edge_cap bit sets at edge k+2.
- Simultaneous detected edge and W1C on the same bit: set wins, and the bit stays 1.
- irq:
  - irq = |(edge_cap & irq_mask), combinational from registers.
  - Goes high at edge k+2 when the bit is unmasked.
  - Unmasking an already-captured bit raises irq the cycle after the mask write.
- Reset asserted mid-operation: all state returns to reset values immediately; no pending edge survives.

Optional Feature:
- Macro PIO_BIT_SETCLR_EN.
- Defined: addresses 4/5 behave as OUTSET/OUTCLR above.
- Undefined: addresses 4/5 are unmapped (writes ignored, reads 0), and no set/clear logic is generated.

Decomposition:
- Package neos2test_pio_pkg:
  - address constants ADDR_DATA..ADDR_OUTCLR.
  - EDGE_TYPE encodings EDGE_RISE/EDGE_FALL/EDGE_ANY.
  - DATA_WIDTH upper-bound constant 32.
- One sub-module, neos2test_pio_sync_edge:
  - holds the s1/s2/s3 vector flops.
  - outputs s2 and the edge-detect vector, selected by EDGE_TYPE.
- The top level holds the register file, read mux and irq.

Test Plan:
- Reset with OUT_RESET=10'h155 -> out_port=10'h155, out_en=10'h3FF, irq=0; read addr 1 -> 0x3FF, addr 2 -> 0, addr 3 -> 0.
- Write DIR=0x00F, DATA=0x3A5, in_port=0x2C0 held -> out_en=0x00F; read addr 0 -> 0x2C5 (upper bits from pins, low nibble 0x5).
- DIR=0, mask=0x001, EDGE_TYPE=0, in_port[0] 0->1 before edge k -> edge_cap=0x001 and irq=1 after edge k+2; write addr 3 = 0x001 -> edge_cap=0, irq=0 next cycle.
- Rising edge on bit 0 detected in the same cycle as a W1C of bit 0 -> edge_cap[0] remains 1, irq stays 1.
- With PIO_BIT_SETCLR_EN: DATA=0x0F0, write OUTSET=0x003 -> out_port=0x0F3; write OUTCLR=0x030 -> 0x0C3. Without the macro: same writes leave out_port=0x0F0 and reads of addr 4/5 return 0.
- Assert reset_n low mid-capture (edge_cap=0x001, irq=1) -> edge_cap=0, irq=0, out_port=OUT_RESET asynchronously; write to addr 7 afterwards -> no register changes.
